// File: rtl/accumulator_ctrl.sv
// Accumulator bank controller: captures column-0 partial sums into
// SYSTOLIC_SIZE accumulator banks (bank j lags bank 0 by j cycles, or all
// banks in lock-step in test mode), then streams the captured rows out
// through a common read address.
//
// Read handshake: rd_valid high means rd_addr names a row the consumer may
// take; the row is transferred on any rising edge where rd_valid && rd_ready.
// While rd_ready is low, rd_addr/rd_last hold. rd_valid never drops without
// a transfer, except on abort or reset.
//
// SYSTOLIC_SIZE is expected to be at least 2 (one delay stage or more).
module accumulator_ctrl #(
  parameter int SYSTOLIC_SIZE  = 8,
  parameter int PATTERN_NUMBER = 4,
  parameter int ADDR_WIDTH     = $clog2(PATTERN_NUMBER * SYSTOLIC_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH:0]                num_rows,
  input  logic                               test_mode,
  input  logic                               abort,
  input  logic                               psum_valid,
  output logic [SYSTOLIC_SIZE-1:0]           wr_en_col,
  output logic [ADDR_WIDTH*SYSTOLIC_SIZE-1:0] wr_addr_flat,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic                               rd_last,
  output logic                               busy,
  output logic                               done,
  output logic [2:0]                         dbg_state
);

  localparam int DEPTH  = PATTERN_NUMBER * SYSTOLIC_SIZE;
  localparam int CHAIN  = SYSTOLIC_SIZE - 1;
  localparam int DW     = (SYSTOLIC_SIZE > 4) ? $clog2(SYSTOLIC_SIZE - 1) : 2;
  localparam int DL_INT = SYSTOLIC_SIZE - 2;
  localparam int ONE_INT = 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_R    = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   ONE_R      = ONE_INT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] ONE_A      = ONE_INT[ADDR_WIDTH-1:0];
  localparam logic [DW-1:0]         ONE_D      = ONE_INT[DW-1:0];
  localparam logic [DW-1:0]         DRAIN_LAST = DL_INT[DW-1:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_DRAIN = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH:0]         num_rows_q, num_rows_d;
  logic                        test_mode_q, test_mode_d;
  logic [ADDR_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]               drain_cnt_q, drain_cnt_d;
  logic [ADDR_WIDTH-1:0]       rd_addr_q, rd_addr_d;
  logic [CHAIN-1:0]            en_chain_q, en_chain_d;
  logic [CHAIN*ADDR_WIDTH-1:0] addr_chain_q, addr_chain_d;

  logic                  start_ok;
  logic                  kill;
  logic                  wr0_en;
  logic [ADDR_WIDTH-1:0] wr0_addr;
  logic                  wr_last;
  logic                  rd_is_last;
  logic                  rd_hs;
  logic [ADDR_WIDTH:0]   last_row;

  // Shared decode: job acceptance, bank-0 write and read-side events.
  assign last_row   = num_rows_q - ONE_R;
  assign start_ok   = start && (num_rows != '0) && (num_rows <= DEPTH_R);
  assign kill       = abort && (state_q != S_IDLE);
  assign wr0_en     = (state_q == S_WRITE) && psum_valid && !abort;
  assign wr0_addr   = wr0_en ? wr_ptr_q : '0;
  assign wr_last    = wr0_en && ({1'b0, wr_ptr_q} == last_row);
  assign rd_is_last = (state_q == S_READ) && ({1'b0, rd_addr_q} == last_row);
  assign rd_hs      = (state_q == S_READ) && rd_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort outranks every other transition.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = S_WRITE;
        S_WRITE: if (wr_last) state_d = test_mode_q ? S_READ : S_DRAIN;
        S_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = S_READ;
        S_READ:  if (rd_hs && rd_is_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: job parameters, pointers, drain count, delay chain.
  always_comb begin
    num_rows_d  = num_rows_q;
    test_mode_d = test_mode_q;
    wr_ptr_d    = wr_ptr_q;
    drain_cnt_d = (state_q == S_DRAIN) ? drain_cnt_q + ONE_D : '0;
    rd_addr_d   = '0;

    if (state_q == S_IDLE && start_ok) begin
      num_rows_d  = num_rows;
      test_mode_d = test_mode;
      wr_ptr_d    = '0;
    end

    // The pointer parks on the last row instead of wrapping.
    if (wr0_en && !wr_last) wr_ptr_d = wr_ptr_q + ONE_A;

    // Read address is zero outside READ so every readout starts at row 0.
    if (state_q == S_READ && !abort) begin
      rd_addr_d = (rd_hs && !rd_is_last) ? rd_addr_q + ONE_A : rd_addr_q;
    end

    // Stage i carries bank-0 enable/address delayed i+1 cycles; test mode
    // bypasses the chain, so only zeros enter it.
    en_chain_d   = '0;
    addr_chain_d = '0;
    if (!kill) begin
      en_chain_d[0]               = wr0_en && !test_mode_q;
      addr_chain_d[0+:ADDR_WIDTH] = (wr0_en && !test_mode_q) ? wr0_addr : '0;
      for (int i = 1; i < CHAIN; i++) begin
        en_chain_d[i]                        = en_chain_q[i-1];
        addr_chain_d[i*ADDR_WIDTH+:ADDR_WIDTH] = addr_chain_q[(i-1)*ADDR_WIDTH+:ADDR_WIDTH];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_rows_q   <= '0;
      test_mode_q  <= 1'b0;
      wr_ptr_q     <= '0;
      drain_cnt_q  <= '0;
      rd_addr_q    <= '0;
      en_chain_q   <= '0;
      addr_chain_q <= '0;
    end else begin
      num_rows_q   <= num_rows_d;
      test_mode_q  <= test_mode_d;
      wr_ptr_q     <= wr_ptr_d;
      drain_cnt_q  <= drain_cnt_d;
      rd_addr_q    <= rd_addr_d;
      en_chain_q   <= en_chain_d;
      addr_chain_q <= addr_chain_d;
    end
  end

  // Outputs: bank write strobes only in WRITE/DRAIN, read side only in READ.
  always_comb begin
    wr_en_col    = '0;
    wr_addr_flat = '0;
    if (state_q == S_WRITE || state_q == S_DRAIN) begin
      if (test_mode_q) begin
        for (int j = 0; j < SYSTOLIC_SIZE; j++) begin
          wr_en_col[j]                            = wr0_en;
          wr_addr_flat[j*ADDR_WIDTH+:ADDR_WIDTH] = wr0_addr;
        end
      end else begin
        wr_en_col[0]                 = wr0_en;
        wr_addr_flat[0+:ADDR_WIDTH] = wr0_addr;
        for (int j = 1; j < SYSTOLIC_SIZE; j++) begin
          wr_en_col[j]                            = en_chain_q[j-1];
          wr_addr_flat[j*ADDR_WIDTH+:ADDR_WIDTH] = addr_chain_q[(j-1)*ADDR_WIDTH+:ADDR_WIDTH];
        end
      end
    end
    rd_addr   = rd_addr_q;
    rd_valid  = (state_q == S_READ);
    rd_last   = rd_is_last;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) && !abort;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Bench for accumulator_ctrl: directed jobs; each job pushes its expected
// write/read/done events (cycle-stamped) into exp_q, and a negedge monitor
// pops and compares every event the DUT presents.
module tb_accumulator_ctrl;

  localparam int S  = 8;
  localparam int PN = 4;
  localparam int AW = 5;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic [AW:0]   num_rows = '0;
  logic          test_mode = 1'b0;
  logic          abort = 1'b0;
  logic          psum_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [S-1:0]  wr_en_col;
  logic [AW*S-1:0] wr_addr_flat;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  accumulator_ctrl #(
    .SYSTOLIC_SIZE (S),
    .PATTERN_NUMBER(PN),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_rows    (num_rows),
    .test_mode   (test_mode),
    .abort       (abort),
    .psum_valid  (psum_valid),
    .wr_en_col   (wr_en_col),
    .wr_addr_flat(wr_addr_flat),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int acc_q[$];

  // Event word: cycle[31:12] kind[11:10] bank[9:6] last[5] addr[4:0]
  // kind 1 = bank write, 2 = read row presented, 3 = done pulse.
  function automatic logic [31:0] mk_ev(int c, int kind, int bank, int last, int addr);
    logic [31:0] e;
    e = {c[19:0], kind[1:0], bank[3:0], last[0], addr[4:0]};
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_take(logic [31:0] got);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected actual cyc=%0d kind=%0d bank=%0d last=%0d addr=%0d required=none",
               got[31:12], got[11:10], got[9:6], got[5], got[4:0]);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL sb_event actual cyc=%0d kind=%0d bank=%0d last=%0d addr=%0d required cyc=%0d kind=%0d bank=%0d last=%0d addr=%0d",
                 got[31:12], got[11:10], got[9:6], got[5], got[4:0],
                 e[31:12], e[11:10], e[9:6], e[5], e[4:0]);
      end
    end
  endtask

  // Monitor: every bank write, every presented read row and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < S; j++)
        if (wr_en_col[j]) sb_take(mk_ev(cyc, 1, j, 0, int'(wr_addr_flat[j*AW +: AW])));
      if (rd_valid) sb_take(mk_ev(cyc, 2, 0, rd_last ? 1 : 0, int'(rd_addr)));
      if (done) sb_take(mk_ev(cyc, 3, 0, 0, 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bank j writes row k at accept cycle k + j (normal) or at accept cycle k (test).
  task automatic push_writes(bit tm, int lim);
    int first, last_c;
    first  = acc_q[0];
    last_c = acc_q[acc_q.size()-1] + (tm ? 0 : S - 1);
    for (int c = first; c <= last_c; c++)
      for (int j = 0; j < S; j++)
        for (int k = 0; k < acc_q.size(); k++)
          if (((tm ? acc_q[k] : acc_q[k] + j) == c) && (c < lim))
            exp_q.push_back(mk_ev(c, 1, j, 0, k));
  endtask

  // Row presented every READ cycle; advances on ready; done one cycle after last transfer.
  task automatic push_reads(int nrows, int t_read, logic [63:0] rdy, int lim, output int t_done);
    int addr;
    int c;
    addr = 0;
    t_done = -1;
    for (int i = 0; i < 64 && t_done < 0; i++) begin
      c = t_read + i;
      if (c < lim) exp_q.push_back(mk_ev(c, 2, 0, (addr == nrows - 1) ? 1 : 0, addr));
      if (rdy[i]) begin
        if (addr == nrows - 1) t_done = c + 1;
        else addr++;
      end
    end
    if (t_done >= 0 && t_done < lim) exp_q.push_back(mk_ev(t_done, 3, 0, 0, 0));
  endtask

  // kill: 0 none, 1 abort during cycle t0+kill_rel, 2 reset during cycle t0+kill_rel.
  task automatic run_job(int nrows, bit tm, logic [63:0] pv, logic [63:0] rdy, int kill, int kill_rel);
    int t0, t_read, t_done, t_kill, lim, t_end, n, i;
    tick();
    start = 1'b1; num_rows = nrows[AW:0]; test_mode = tm;
    psum_valid = 1'b0; rd_ready = 1'b0; abort = 1'b0;
    t0 = cyc + 1;
    acc_q.delete();
    n = 0;
    for (int b = 0; b < 64; b++)
      if (pv[b] && n < nrows) begin
        acc_q.push_back(t0 + b);
        n++;
      end
    t_kill = t0 + kill_rel;
    lim = (kill == 0) ? 32'h7fff_ffff : ((kill == 1) ? t_kill + 1 : t_kill);
    push_writes(tm, lim);
    t_read = acc_q[acc_q.size()-1] + 1 + (tm ? 0 : S - 1);
    push_reads(nrows, t_read, rdy, lim, t_done);
    t_end = (kill == 0) ? t_done + 1 : t_kill + 1;

    for (int g = 0; g < 200; g++) begin
      tick();
      start = 1'b0;
      i = cyc - t0;
      psum_valid = (i >= 0 && i < 64) ? pv[i] : 1'b0;
      rd_ready = (cyc >= t_read && cyc - t_read < 64) ? rdy[cyc - t_read] : 1'b0;
      abort = (kill == 1 && cyc == t_kill);
      #1;
      if (cyc == t0) check("busy_in_write", busy, 1);
      if (kill == 2 && cyc == t_kill) begin
        rst_n = 1'b0;
        #1;
        check("rst_wr_en_col", wr_en_col, 0);
        check("rst_wr_addr", wr_addr_flat, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
      end
      if (cyc == t_end) begin
        check("busy_after_job", busy, 0);
        check("done_after_job", done, 0);
        check("state_after_job", dbg_state, 0);
        if (kill == 1) check("wr_en_after_abort", wr_en_col, 0);
        break;
      end
    end
    psum_valid = 1'b0; rd_ready = 1'b0; abort = 1'b0;
  endtask

  task automatic try_bad(int n);
    tick();
    start = 1'b1; num_rows = n[AW:0]; test_mode = 1'b0;
    tick();
    start = 1'b0;
    #1;
    check("bad_start_busy", busy, 0);
    check("bad_start_state", dbg_state, 0);
    tick();
    check("bad_start_busy_later", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_wr_en_col", wr_en_col, 0);
    check("reset_wr_addr", wr_addr_flat, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Normal, 3 rows, psum_valid held one extra cycle (must be ignored).
    run_job(3, 1'b0, 64'hF, ALL1, 0, 0);
    // Test mode, 4 rows: all banks together, no drain.
    run_job(4, 1'b1, 64'h3F, ALL1, 0, 0);
    // psum_valid 1,0,1,1 and consumer stalls 5 cycles at row 1.
    run_job(3, 1'b0, 64'hD, 64'hFFFF_FFFF_FFFF_FFC1, 0, 0);
    // Out-of-range row counts are ignored.
    try_bad(0);
    try_bad(33);
    // Full-depth job aborted in the third DRAIN cycle.
    run_job(32, 1'b0, ALL1, ALL1, 1, 34);
    // Full-depth test-mode job right after the abort.
    run_job(32, 1'b1, ALL1, ALL1, 0, 0);
    // Reset asserted during READ (second row).
    run_job(2, 1'b0, ALL1, ALL1, 2, 10);
    tick();
    rst_n = 1'b1;
    tick();
    // Single-row job after reset release.
    run_job(1, 1'b0, 64'h1, ALL1, 0, 0);

    repeat (3) tick();
    check("sb_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_ctrl.md
ACCUMULATOR_CTRL -- requirements
Module: accumulator_ctrl

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, array columns (= accumulator banks).
REQ-002 SHALL have parameter PATTERN_NUMBER, default 4, patterns per bank.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(PATTERN_NUMBER*SYSTOLIC_SIZE), bank address width; DEPTH = PATTERN_NUMBER*SYSTOLIC_SIZE.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a capture/readout job.
REQ-007 SHALL have port num_rows  input  ADDR_WIDTH+1  rows to capture, sampled with start.
REQ-008 SHALL have port test_mode  input  1  unskewed write mode, sampled with start.
REQ-009 SHALL have port abort  input  1  synchronous job cancel.
REQ-010 SHALL have port psum_valid  input  1  column-0 partial sum valid from array.
REQ-011 SHALL have port wr_en_col  output  SYSTOLIC_SIZE  per-bank write enable.
REQ-012 SHALL have port wr_addr_flat  output  ADDR_WIDTH*SYSTOLIC_SIZE  per-bank write address, bank j at [j*ADDR_WIDTH +: ADDR_WIDTH].
REQ-013 SHALL have port rd_addr  output  ADDR_WIDTH  common read address to all banks.
REQ-014 SHALL have port rd_valid  output  1  rd_addr valid for consumer.
REQ-015 SHALL have port rd_ready  input  1  consumer accepts current row.
REQ-016 SHALL have port rd_last  output  1  current read row is last.
REQ-017 SHALL have ports busy, done  output  1 each  job active / one-cycle job completion pulse.

Function
REQ-018 SHALL implement FSM IDLE, WRITE, DRAIN, READ, DONE.
REQ-019 IDLE: start with 1<=num_rows<=DEPTH SHALL latch num_rows, test_mode, clear wr_ptr, go WRITE; other num_rows values, or start outside IDLE, SHALL be ignored.
REQ-020 WRITE: each cycle with psum_valid=1 SHALL assert bank-0 write at wr_ptr and increment wr_ptr; psum_valid=0 SHALL stall with no write.
REQ-021 Normal mode: bank j enable/address SHALL equal bank-0 enable/address delayed exactly j cycles via a shift chain of SYSTOLIC_SIZE-1 stages.
REQ-022 Test mode: all banks SHALL be written in the same cycle as bank 0 with bank-0 address; delay chain bypassed.
REQ-023 When accepted rows reach num_rows SHALL leave WRITE the same edge; further psum_valid SHALL be ignored.
REQ-024 DRAIN: normal mode SHALL wait SYSTOLIC_SIZE-1 cycles (last bank written in final DRAIN cycle), then READ; test mode SHALL skip DRAIN (WRITE->READ directly).
REQ-025 READ: rd_addr SHALL start at 0 with rd_valid=1; on rd_valid&&rd_ready rd_addr SHALL increment; rd_addr SHALL hold stable while rd_ready=0.
REQ-026 rd_last SHALL equal rd_valid && rd_addr==num_rows-1; handshake on last row SHALL go DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; busy SHALL be 1 in every state except IDLE.
REQ-028 wr_ptr SHALL never wrap; address never exceeds num_rows-1.
REQ-029 abort in any non-IDLE state SHALL go IDLE next edge, clear delay chain and all enables, no done pulse; abort has priority over every other event; abort in IDLE SHALL have no effect.
REQ-030 wr_en_col SHALL be 0 outside WRITE/DRAIN; rd_valid SHALL be 0 outside READ.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, wr_en_col=0, wr_addr_flat=0, rd_addr=0, rd_valid=0, rd_last=0, busy=0, done=0, clear delay chain and wr_ptr.
REQ-032 Reset mid-job SHALL discard the job; first start after release SHALL behave as from power-up.

Verification
REQ-033 num_rows=3, normal, psum_valid high 3 cycles (T0..T2) -> bank0 writes addr 0,1,2 at T0..T2; bank7 writes 0,1,2 at T7..T9; READ entered T10; done after 3 handshakes.
REQ-034 test_mode=1, num_rows=4 -> wr_en_col=8'hFF with same address 0..3 for 4 cycles; no DRAIN; rd_valid next cycle.
REQ-035 psum_valid pattern 1,0,1,1 with num_rows=3 -> bank0 addresses 0,-,1,2; bank3 same pattern shifted 3 cycles.
REQ-036 READ with rd_ready low 5 cycles at rd_addr=1 -> rd_addr holds 1, rd_valid stays 1; rd_last only at addr num_rows-1.
REQ-037 abort during DRAIN, num_rows=32 -> wr_en_col=0 next cycle, busy=0, no done; new start accepted.
REQ-038 start with num_rows=0 and 33 -> ignored, busy stays 0; rst_n low during READ -> all outputs 0 immediately.
